// File: rtl/lock_pkg.sv
// Shared types and constants for the canal-lock sequencer.
package lock_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPrep,
    StEnter,
    StEnterOpen,
    StAdjust,
    StExit,
    StExitOpen,
    StDone
  } lock_state_e;

  localparam logic DIR_DOWN = 1'b0;
  localparam logic DIR_UP   = 1'b1;

  // Downstream passages enter through gate1 (high side).
  function automatic logic entry_on_gate1(logic dir);
    return dir == DIR_DOWN;
  endfunction

endpackage

// File: rtl/lock_sequencer_if.sv
// Board-side switch/LED bundle of the lock sequencer; master = board, slave = sequencer.
interface lock_sequencer_if #(
  parameter int unsigned LEVEL_W = 4,
  parameter int unsigned CNT_W   = 8
) ();

  logic               arr_sw;
  logic               dep_sw;
  logic               dir;
  logic               gate1_sw;
  logic               gate2_sw;
  logic [LEVEL_W-1:0] level;
  logic               gate1_li;
  logic               gate2_li;
  logic               arr_li;
  logic               dep_li;
  logic               occupied;
  logic               exited;
  logic [CNT_W-1:0]   boat_cnt;
  logic               busy;

  modport master (
    output arr_sw, dep_sw, dir, gate1_sw, gate2_sw,
    input  level, gate1_li, gate2_li, arr_li, dep_li, occupied, exited, boat_cnt, busy
  );

  modport slave (
    input  arr_sw, dep_sw, dir, gate1_sw, gate2_sw,
    output level, gate1_li, gate2_li, arr_li, dep_li, occupied, exited, boat_cnt, busy
  );

endinterface

// File: rtl/lock_level_ctr.sv
// Water-level register: moves toward a target by at most one step per enabled clock,
// clamping the final step so the target is never overshot.
module lock_level_ctr #(
  parameter int unsigned         LEVEL_W     = 4,
  parameter int unsigned         FILL_STEP   = 1,
  parameter int unsigned         DRAIN_STEP  = 1,
  parameter logic [LEVEL_W-1:0]  RESET_LEVEL = '0
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               en_i,
  input  logic               up_i,
  input  logic [LEVEL_W-1:0] target_i,
  output logic [LEVEL_W-1:0] level_o
);

  logic [LEVEL_W-1:0] level_q, level_d;
  logic [LEVEL_W-1:0] diff, step;

  always_comb begin
    diff = up_i ? (target_i - level_q) : (level_q - target_i);
    step = diff;
    if (up_i) begin
      if (32'(diff) > FILL_STEP) step = LEVEL_W'(FILL_STEP);
    end else begin
      if (32'(diff) > DRAIN_STEP) step = LEVEL_W'(DRAIN_STEP);
    end
    level_d = level_q;
    if (en_i) level_d = up_i ? (level_q + step) : (level_q - step);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) level_q <= RESET_LEVEL;
    else         level_q <= level_d;
  end

  assign level_o = level_q;

endmodule

// File: rtl/lock_sequencer.sv
// Bidirectional canal-lock controller: sequences water level, gates and boat passage,
// and counts completed passages.
module lock_sequencer
  import lock_pkg::*;
#(
  parameter int unsigned LEVEL_W    = 4,
  parameter int unsigned LEVEL_LOW  = 2,
  parameter int unsigned LEVEL_HIGH = 8,
  parameter int unsigned FILL_STEP  = 1,
  parameter int unsigned DRAIN_STEP = 1,
  parameter int unsigned CNT_W      = 8
) (
  input logic              clk,
  input logic              reset,
  lock_sequencer_if.slave  bus
);

  if (!(LEVEL_LOW < LEVEL_HIGH && LEVEL_HIGH <= (1 << LEVEL_W) - 1 &&
        FILL_STEP >= 1 && DRAIN_STEP >= 1)) begin : gen_bad_cfg
    $error("lock_sequencer: illegal level/step configuration");
  end

  localparam logic [LEVEL_W-1:0] LvlLow  = LEVEL_W'(LEVEL_LOW);
  localparam logic [LEVEL_W-1:0] LvlHigh = LEVEL_W'(LEVEL_HIGH);

  lock_state_e        state_q, state_d;
  logic               dir_q, dir_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [LEVEL_W-1:0] level;

  logic               entry_g1;
  logic               entry_sw, exit_sw;
  logic [LEVEL_W-1:0] entry_lvl, exit_lvl, target;
  logic               lvl_en, lvl_up, at_target;

  assign entry_g1  = entry_on_gate1(dir_q);
  assign entry_sw  = entry_g1 ? bus.gate1_sw : bus.gate2_sw;
  assign exit_sw   = entry_g1 ? bus.gate2_sw : bus.gate1_sw;
  assign entry_lvl = entry_g1 ? LvlHigh : LvlLow;
  assign exit_lvl  = entry_g1 ? LvlLow : LvlHigh;
  assign target    = (state_q == StAdjust) ? exit_lvl : entry_lvl;
  assign lvl_en    = (state_q == StPrep) || (state_q == StAdjust);
  assign lvl_up    = target > level;
  assign at_target = level == target;

  lock_level_ctr #(
    .LEVEL_W     (LEVEL_W),
    .FILL_STEP   (FILL_STEP),
    .DRAIN_STEP  (DRAIN_STEP),
    .RESET_LEVEL (LvlLow)
  ) u_level (
    .clk_i    (clk),
    .reset_i  (reset),
    .en_i     (lvl_en),
    .up_i     (lvl_up),
    .target_i (target),
    .level_o  (level)
  );

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (bus.arr_sw) begin
          state_d = StPrep;
          dir_d   = bus.dir;
        end
      end
      StPrep:      if (at_target) state_d = StEnter;
      StEnter:     if (entry_sw) state_d = StEnterOpen;
      StEnterOpen: if (!entry_sw && !bus.arr_sw) state_d = StAdjust;
      StAdjust:    if (at_target) state_d = StExit;
      StExit:      if (bus.dep_sw && exit_sw) state_d = StExitOpen;
      StExitOpen:  if (!bus.dep_sw && !exit_sw) state_d = StDone;
      StDone: begin
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = StIdle;
      end
      default:     state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      dir_q   <= DIR_DOWN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
    end
  end

  // Only one of the *_OPEN states can be live, so the gate lights stay exclusive.
  assign bus.gate1_li = ((state_q == StEnterOpen) && entry_g1) ||
                        ((state_q == StExitOpen) && !entry_g1);
  assign bus.gate2_li = ((state_q == StEnterOpen) && !entry_g1) ||
                        ((state_q == StExitOpen) && entry_g1);
  assign bus.occupied = (state_q == StAdjust) || (state_q == StExit) ||
                        (state_q == StExitOpen) || (state_q == StDone);
  assign bus.exited   = state_q == StDone;
  assign bus.busy     = state_q != StIdle;
  assign bus.arr_li   = bus.arr_sw && (state_q == StIdle);
  assign bus.dep_li   = bus.dep_sw && bus.occupied;
  assign bus.level    = level;
  assign bus.boat_cnt = cnt_q;

endmodule

// File: tb/tb_lock_sequencer.sv
// Bench for lock_sequencer: two configurations checked every cycle against a behavioural
// passage model, plus directed passages with hand-computed expectations.
module tb_lock_sequencer;

  localparam int Low  = 2;
  localparam int High = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  int fill[2]    = '{1, 3};
  int drain[2]   = '{1, 2};
  int cnt_mod[2] = '{256, 4};

  logic rst_v[2] = '{1'b1, 1'b1};
  logic arr_v[2] = '{1'b0, 1'b0};
  logic dep_v[2] = '{1'b0, 1'b0};
  logic dir_v[2] = '{1'b0, 1'b0};
  logic g1_v[2]  = '{1'b0, 1'b0};
  logic g2_v[2]  = '{1'b0, 1'b0};

  logic [3:0] lvl_o[2];
  logic [7:0] cnt_o[2];
  logic       g1_o[2], g2_o[2], arr_li_o[2], dep_li_o[2];
  logic       occ_o[2], exited_o[2], busy_o[2];

  lock_sequencer_if #(.LEVEL_W(4), .CNT_W(8)) bus0 ();
  lock_sequencer_if #(.LEVEL_W(4), .CNT_W(2)) bus1 ();

  assign bus0.arr_sw = arr_v[0];  assign bus1.arr_sw = arr_v[1];
  assign bus0.dep_sw = dep_v[0];  assign bus1.dep_sw = dep_v[1];
  assign bus0.dir = dir_v[0];     assign bus1.dir = dir_v[1];
  assign bus0.gate1_sw = g1_v[0]; assign bus1.gate1_sw = g1_v[1];
  assign bus0.gate2_sw = g2_v[0]; assign bus1.gate2_sw = g2_v[1];

  assign lvl_o[0] = bus0.level;            assign lvl_o[1] = bus1.level;
  assign cnt_o[0] = bus0.boat_cnt;         assign cnt_o[1] = {6'd0, bus1.boat_cnt};
  assign g1_o[0] = bus0.gate1_li;          assign g1_o[1] = bus1.gate1_li;
  assign g2_o[0] = bus0.gate2_li;          assign g2_o[1] = bus1.gate2_li;
  assign arr_li_o[0] = bus0.arr_li;        assign arr_li_o[1] = bus1.arr_li;
  assign dep_li_o[0] = bus0.dep_li;        assign dep_li_o[1] = bus1.dep_li;
  assign occ_o[0] = bus0.occupied;         assign occ_o[1] = bus1.occupied;
  assign exited_o[0] = bus0.exited;        assign exited_o[1] = bus1.exited;
  assign busy_o[0] = bus0.busy;            assign busy_o[1] = bus1.busy;

  lock_sequencer #(
    .LEVEL_W(4), .LEVEL_LOW(2), .LEVEL_HIGH(8), .FILL_STEP(1), .DRAIN_STEP(1), .CNT_W(8)
  ) dut0 (.clk(clk), .reset(rst_v[0]), .bus(bus0));

  lock_sequencer #(
    .LEVEL_W(4), .LEVEL_LOW(2), .LEVEL_HIGH(8), .FILL_STEP(3), .DRAIN_STEP(2), .CNT_W(2)
  ) dut1 (.clk(clk), .reset(rst_v[1]), .bus(bus1));

  // Model: phase 0 idle, 1 prepare, 2 await entry gate, 3 entry gate open,
  // 4 adjust, 5 await exit, 6 exit gate open, 7 passage done.
  int ph[2]       = '{0, 0};
  int lvl[2]      = '{Low, Low};
  int cnt[2]      = '{0, 0};
  int md[2]       = '{0, 0};
  int passages[2] = '{0, 0};

  task automatic chk(input string nm, input int k, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s[%0d] @%0t: got %0d, expected %0d", nm, k, $time, act, exp);
    end
  endtask

  function automatic int toward(input int k, input int l, input int t);
    if (l < t) return l + ((t - l) < fill[k] ? (t - l) : fill[k]);
    return l - ((l - t) < drain[k] ? (l - t) : drain[k]);
  endfunction

  initial forever begin
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      automatic int eg = (md[k] != 0) ? 2 : 1;
      automatic int og = (ph[k] == 3) ? eg : (ph[k] == 6) ? 3 - eg : 0;
      automatic bit occ = ph[k] >= 4;
      automatic bit ent_sw = (eg == 1) ? g1_v[k] : g2_v[k];
      automatic bit ext_sw = (eg == 1) ? g2_v[k] : g1_v[k];
      chk("level", k, int'(lvl_o[k]), lvl[k]);
      chk("boat_cnt", k, int'(cnt_o[k]), cnt[k]);
      chk("gate1_li", k, int'(g1_o[k]), int'(og == 1));
      chk("gate2_li", k, int'(g2_o[k]), int'(og == 2));
      chk("lights_excl", k, int'(g1_o[k] & g2_o[k]), 0);
      chk("occupied", k, int'(occ_o[k]), int'(occ));
      chk("exited", k, int'(exited_o[k]), int'(ph[k] == 7));
      chk("busy", k, int'(busy_o[k]), int'(ph[k] != 0));
      chk("arr_li", k, int'(arr_li_o[k]), int'(arr_v[k] && ph[k] == 0));
      chk("dep_li", k, int'(dep_li_o[k]), int'(dep_v[k] && occ));
      if (rst_v[k]) begin
        ph[k] = 0; lvl[k] = Low; cnt[k] = 0; md[k] = 0;
      end else begin
        case (ph[k])
          0: if (arr_v[k]) begin md[k] = int'(dir_v[k]); ph[k] = 1; end
          1: begin
            automatic int t = (md[k] != 0) ? Low : High;
            if (lvl[k] == t) ph[k] = 2; else lvl[k] = toward(k, lvl[k], t);
          end
          2: if (ent_sw) ph[k] = 3;
          3: if (!ent_sw && !arr_v[k]) ph[k] = 4;
          4: begin
            automatic int t = (md[k] != 0) ? High : Low;
            if (lvl[k] == t) ph[k] = 5; else lvl[k] = toward(k, lvl[k], t);
          end
          5: if (dep_v[k] && ext_sw) ph[k] = 6;
          6: if (!dep_v[k] && !ext_sw) ph[k] = 7;
          default: begin
            cnt[k] = (cnt[k] + 1) % cnt_mod[k];
            ph[k] = 0;
            passages[k]++;
          end
        endcase
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int k, input bit a, input bit d, input bit dr,
                        input bit s1, input bit s2);
    arr_v[k] = a; dep_v[k] = d; dir_v[k] = dr; g1_v[k] = s1; g2_v[k] = s2;
  endtask

  // Drives instance k through one full passage from wherever it is, bounded in cycles.
  task automatic run_passage(input int k, input bit dv);
    automatic int start = passages[k];
    automatic int budget = 0;
    while (passages[k] == start && budget < 80) begin
      case (ph[k])
        0: set_in(k, 1, 0, dv, 0, 0);
        2: if (md[k] != 0) set_in(k, 0, 0, dv, 0, 1); else set_in(k, 0, 0, dv, 1, 0);
        5: if (md[k] != 0) set_in(k, 0, 1, dv, 1, 0); else set_in(k, 0, 1, dv, 0, 1);
        default: set_in(k, 0, 0, dv, 0, 0);
      endcase
      cyc();
      budget++;
    end
    set_in(k, 0, 0, dv, 0, 0);
    chk("passage_completes", k, int'(passages[k] != start), 1);
  endtask

  initial begin
    repeat (2) cyc();
    rst_v[0] = 1'b0; rst_v[1] = 1'b0;
    chk("rst_level", 0, int'(lvl_o[0]), 2);
    chk("rst_cnt", 0, int'(cnt_o[0]), 0);
    chk("rst_busy", 0, int'(busy_o[0]), 0);

    // Downstream on instance 0; dir toggled after capture must not matter.
    set_in(0, 1, 0, 0, 0, 0); cyc();
    chk("prep_busy", 0, int'(busy_o[0]), 1);
    set_in(0, 0, 0, 1, 0, 0);
    repeat (6) cyc();
    chk("fill_to_8", 0, int'(lvl_o[0]), 8);
    cyc();
    set_in(0, 0, 0, 1, 1, 0); cyc();
    chk("entry_g1_li", 0, int'(g1_o[0]), 1);
    chk("entry_g2_li", 0, int'(g2_o[0]), 0);
    chk("entry_occ", 0, int'(occ_o[0]), 0);
    set_in(0, 0, 0, 1, 0, 0); cyc();
    chk("adjust_g1_li", 0, int'(g1_o[0]), 0);
    chk("adjust_occ", 0, int'(occ_o[0]), 1);
    repeat (6) cyc();
    chk("drain_to_2", 0, int'(lvl_o[0]), 2);
    cyc();
    set_in(0, 0, 1, 1, 0, 1); cyc();
    chk("exit_g2_li", 0, int'(g2_o[0]), 1);
    chk("exit_dep_li", 0, int'(dep_li_o[0]), 1);
    set_in(0, 0, 0, 1, 0, 0); cyc();
    chk("done_exited", 0, int'(exited_o[0]), 1);
    cyc();
    chk("after_exited", 0, int'(exited_o[0]), 0);
    chk("after_cnt", 0, int'(cnt_o[0]), 1);
    chk("after_level", 0, int'(lvl_o[0]), 2);

    // Upstream on instance 0: PREP is immediate, gate1 ignored in ENTER.
    set_in(0, 1, 0, 1, 0, 0); cyc();
    set_in(0, 0, 0, 0, 0, 0); cyc();
    set_in(0, 0, 0, 0, 1, 0); cyc();
    chk("up_wrong_gate_g1", 0, int'(g1_o[0]), 0);
    chk("up_wrong_gate_g2", 0, int'(g2_o[0]), 0);
    set_in(0, 0, 0, 0, 0, 1); cyc();
    chk("up_entry_g2_li", 0, int'(g2_o[0]), 1);
    set_in(0, 0, 0, 0, 0, 0); cyc();
    repeat (6) cyc();
    chk("up_fill_to_8", 0, int'(lvl_o[0]), 8);
    cyc();
    set_in(0, 0, 1, 0, 1, 0); cyc();
    chk("up_exit_g1_li", 0, int'(g1_o[0]), 1);
    set_in(0, 0, 0, 0, 0, 0); cyc(); cyc();
    chk("up_cnt", 0, int'(cnt_o[0]), 2);
    chk("up_level_holds", 0, int'(lvl_o[0]), 8);

    // Instance 1: reset while adjusting at level 5.
    set_in(1, 1, 0, 1, 0, 0); cyc();
    set_in(1, 0, 0, 1, 1, 0); cyc(); cyc();
    set_in(1, 0, 0, 1, 0, 1); cyc();
    set_in(1, 0, 0, 1, 0, 0); cyc(); cyc();
    chk("adj_level_5", 1, int'(lvl_o[1]), 5);
    rst_v[1] = 1'b1; cyc(); rst_v[1] = 1'b0;
    chk("midrst_level", 1, int'(lvl_o[1]), 2);
    chk("midrst_busy", 1, int'(busy_o[1]), 0);
    chk("midrst_occ", 1, int'(occ_o[1]), 0);
    chk("midrst_exited", 1, int'(exited_o[1]), 0);

    // Step 3 fill: 2, 5, 8 with no overshoot, then five passages wrap the 2-bit count.
    set_in(1, 1, 0, 0, 0, 0); cyc();
    set_in(1, 0, 0, 0, 0, 0);
    chk("step3_a", 1, int'(lvl_o[1]), 2);
    cyc(); chk("step3_b", 1, int'(lvl_o[1]), 5);
    cyc(); chk("step3_c", 1, int'(lvl_o[1]), 8);
    run_passage(1, 0);
    for (int i = 0; i < 4; i++) run_passage(1, 1'(i));
    chk("cnt_wrap", 1, int'(cnt_o[1]), 1);

    // Random phase: free-running switches with occasional resets.
    for (int c = 0; c < 4000; c++) begin
      for (int k = 0; k < 2; k++) begin
        rst_v[k] = ($urandom_range(0, 149) == 0);
        set_in(k, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)));
      end
      cyc();
    end
    rst_v[0] = 1'b0; rst_v[1] = 1'b0;
    chk("random_progress", 0, int'(passages[0] > 20), 1);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
